// File: rtl/kaipokrandt_bus_arbiter_pkg.sv
// +--------------------------------------------------------------------------+
// | kaipokrandt_bus_arbiter_pkg: shared states, defaults and width helper.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package kaipokrandt_bus_arbiter_pkg;

  localparam int unsigned c_def_nreq        = 4;
  localparam int unsigned c_def_max_hold    = 8;
  localparam int unsigned c_def_turn_cycles = 1;

  // owner/last_owner are always 3 bits wide (NREQ <= 8)
  localparam int unsigned c_owner_w = 3;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_own  = 2'd1;
  localparam logic [1:0] c_st_turn = 2'd2;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/kaipokrandt_rr_pick.sv
// +--------------------------------------------------------------------------+
// | kaipokrandt_rr_pick: combinational round-robin winner search.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module kaipokrandt_rr_pick
  import kaipokrandt_bus_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = c_def_nreq
) (
  input  logic [NREQ-1:0]      req,
  input  logic [c_owner_w-1:0] last_owner,
  output logic [c_owner_w-1:0] winner,
  output logic                 any
);

  localparam int unsigned c_iw = cnt_width(NREQ);

  logic [c_iw-1:0] w_idx;

  // Walk from the farthest candidate to the nearest so the nearest set bit
  // after last_owner is the final assignment.
  always_comb begin
    w_idx  = '0;
    winner = '0;
    for (int i = NREQ; i >= 1; i--) begin
      w_idx = c_iw'((int'(last_owner) + i) % NREQ);
      if (req[w_idx]) begin
        winner = c_owner_w'(w_idx);
      end
    end
  end

  assign any = |req;

endmodule

`default_nettype wire

// File: rtl/kaipokrandt_bus_arbiter.sv
// +--------------------------------------------------------------------------+
// | kaipokrandt_bus_arbiter: round-robin tristate bus owner with hold limit  |
// | and all-off turnaround. Revision: 1.0                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module kaipokrandt_bus_arbiter
  import kaipokrandt_bus_arbiter_pkg::*;
#(
  parameter int unsigned NREQ        = c_def_nreq,
  parameter int unsigned MAX_HOLD    = c_def_max_hold,
  parameter int unsigned TURN_CYCLES = c_def_turn_cycles
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  output logic [NREQ-1:0]      gnt,
  output logic [c_owner_w-1:0] owner,
  output logic                 busy,
  output logic                 turn
);

  localparam int unsigned c_hw = cnt_width(MAX_HOLD);
  localparam int unsigned c_tw = cnt_width(TURN_CYCLES);
  localparam logic [c_hw-1:0] c_hold_max  = c_hw'(MAX_HOLD - 1);
  localparam logic [c_tw-1:0] c_turn_last = c_tw'(TURN_CYCLES - 1);
  localparam logic [NREQ-1:0] c_gnt_one   = {{(NREQ-1){1'b0}}, 1'b1};

  logic [1:0]           r_state, w_state_nxt;
  logic [NREQ-1:0]      r_gnt, w_gnt_nxt;
  logic [c_owner_w-1:0] r_owner, w_owner_nxt;
  logic [c_owner_w-1:0] r_last, w_last_nxt;
  logic [c_hw-1:0]      r_hold, w_hold_nxt;
  logic [c_tw-1:0]      r_tcnt, w_tcnt_nxt;

  logic [c_owner_w-1:0] w_winner;
  logic                 w_any;
  logic                 w_own_req;
  logic                 w_others_req;
  logic                 w_preempt;
  logic                 w_take;

  kaipokrandt_rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req        (req),
    .last_owner (r_last),
    .winner     (w_winner),
    .any        (w_any)
  );

  // r_gnt is one-hot on the owner while in OWN, so it doubles as the mask.
  assign w_own_req    = |(req & r_gnt);
  assign w_others_req = |(req & ~r_gnt);
  assign w_preempt    = (r_hold == c_hold_max) && w_others_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_st_idle;
      r_gnt   <= '0;
      r_owner <= '0;
      r_last  <= c_owner_w'(NREQ - 1);
      r_hold  <= '0;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_hold  <= w_hold_nxt;
      r_tcnt  <= w_tcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_hold_nxt  = r_hold;
    w_tcnt_nxt  = r_tcnt;
    w_take      = 1'b0;

    case (r_state)
      c_st_idle: begin
        w_take = w_any;
      end

      c_st_own: begin
        if (!w_own_req || w_preempt) begin
          w_state_nxt = c_st_turn;
          w_gnt_nxt   = '0;
          w_tcnt_nxt  = '0;
        end else if (r_hold != c_hold_max) begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end

      c_st_turn: begin
        // Requests are only looked at on the final turnaround edge.
        if (r_tcnt == c_turn_last) begin
          if (w_any) begin
            w_take = 1'b1;
          end else begin
            w_state_nxt = c_st_idle;
          end
        end else begin
          w_tcnt_nxt = r_tcnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = c_st_idle;
        w_gnt_nxt   = '0;
      end
    endcase

    if (w_take) begin
      w_state_nxt = c_st_own;
      w_gnt_nxt   = c_gnt_one << w_winner;
      w_owner_nxt = w_winner;
      w_last_nxt  = w_winner;
      w_hold_nxt  = '0;
    end
  end

  always_comb begin
    gnt   = r_gnt;
    owner = r_owner;
    busy  = |r_gnt;
    turn  = (r_state == c_st_turn);
  end

endmodule

`default_nettype wire

// File: tb/tb_kaipokrandt_bus_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_kaipokrandt_bus_arbiter: directed and random checks of the arbiter.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_kaipokrandt_bus_arbiter;

  localparam int unsigned NREQ        = 4;
  localparam int unsigned MAX_HOLD    = 4;
  localparam int unsigned TURN_CYCLES = 1;
  localparam int          c_starve    = NREQ * (MAX_HOLD + TURN_CYCLES);

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req   = 4'b0000;
  logic [3:0] gnt;
  logic [2:0] owner;
  logic       busy;
  logic       turn;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  kaipokrandt_bus_arbiter #(
    .NREQ        (NREQ),
    .MAX_HOLD    (MAX_HOLD),
    .TURN_CYCLES (TURN_CYCLES)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .gnt   (gnt),
    .owner (owner),
    .busy  (busy),
    .turn  (turn)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  logic [3:0] exp_gnt  [14] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                                4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
                                4'b0001, 4'b0001, 4'b0001, 4'b0001};
  logic       exp_turn [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                1'b0, 1'b0, 1'b0, 1'b0};

  logic [3:0] prev_gnt;
  int         wait_cnt [4];
  int         worst;

  initial begin
    // All requesting through reset
    req   = 4'b1111;
    reset = 1'b0;
    tick();
    tick();
    check_value("rst_gnt",   32'(gnt),   32'h0);
    check_value("rst_busy",  32'(busy),  32'h0);
    check_value("rst_turn",  32'(turn),  32'h0);
    check_value("rst_owner", 32'(owner), 32'h0);
    reset = 1'b1;
    tick();
    check_value("first_gnt",   32'(gnt),   32'h1);
    check_value("first_owner", 32'(owner), 32'h0);
    check_value("first_busy",  32'(busy),  32'h1);
    tick();
    tick();
    tick();
    check_value("hold_last_gnt", 32'(gnt), 32'h1);
    tick();
    check_value("preempt_gnt",  32'(gnt),  32'h0);
    check_value("preempt_turn", 32'(turn), 32'h1);
    tick();
    check_value("rr_next_gnt",   32'(gnt),   32'h2);
    check_value("rr_next_owner", 32'(owner), 32'h1);

    // Asynchronous reset between edges while owned
    #1;
    reset = 1'b0;
    #1;
    check_value("async_rst_gnt",   32'(gnt),   32'h0);
    check_value("async_rst_busy",  32'(busy),  32'h0);
    check_value("async_rst_owner", 32'(owner), 32'h0);
    req   = 4'b0010;
    reset = 1'b1;
    tick();
    check_value("post_rst_gnt",   32'(gnt),   32'h2);
    check_value("post_rst_owner", 32'(owner), 32'h1);

    // Lone requester is never preempted
    req = 4'b0100;
    apply_reset();
    tick();
    check_value("lone_first_gnt", 32'(gnt), 32'h4);
    for (int k = 0; k < 10; k++) begin
      tick();
      check_value("lone_gnt",  32'(gnt),  32'h4);
      check_value("lone_turn", 32'(turn), 32'h0);
    end

    // Owner releases while another waits
    req = 4'b1001;
    apply_reset();
    tick();
    check_value("rel_first_gnt", 32'(gnt), 32'h1);
    req = 4'b1000;
    tick();
    check_value("rel_gap_gnt",  32'(gnt),  32'h0);
    check_value("rel_gap_turn", 32'(turn), 32'h1);
    tick();
    check_value("rel_new_gnt",   32'(gnt),   32'h8);
    check_value("rel_new_owner", 32'(owner), 32'h3);

    // Two constant requesters alternate
    req = 4'b0011;
    apply_reset();
    for (int k = 0; k < 14; k++) begin
      tick();
      check_value("alt_gnt",  32'(gnt),  32'(exp_gnt[k]));
      check_value("alt_turn", 32'(turn), 32'(exp_turn[k]));
    end

    // Random sticky requests: waiting requesters hold req until served
    req = 4'b0000;
    apply_reset();
    prev_gnt = 4'b0000;
    for (int j = 0; j < 4; j++) wait_cnt[j] = 0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      check_value("rand_onehot0", 32'($countones(gnt) <= 1), 32'h1);
      check_value("rand_gap", 32'((prev_gnt != 4'b0000) && (gnt != 4'b0000) && (gnt != prev_gnt)), 32'h0);
      worst = 0;
      for (int j = 0; j < 4; j++) begin
        if (req[j] && !gnt[j]) wait_cnt[j]++;
        else wait_cnt[j] = 0;
        if (wait_cnt[j] > worst) worst = wait_cnt[j];
      end
      check_value("rand_starve", 32'(worst > c_starve), 32'h0);
      prev_gnt = gnt;
      for (int j = 0; j < 4; j++) begin
        if (gnt[j]) begin
          if ($urandom_range(7) == 0) req[j] = 1'b0;
        end else if (!req[j]) begin
          if ($urandom_range(2) == 0) req[j] = 1'b1;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
